// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the issue-hazard scoreboard.
// One issue slot is bundled as issue_slot_t once it is unpacked from the flat ports.
package hazard_pkg;

   localparam int DEF_ISSUE_WIDTH = 2;
   localparam int DEF_NUM_REGS    = 32;
   localparam int DEF_LAT_W       = 3;
   localparam int DEF_DIV_LAT     = 6;

   typedef logic [4:0]           reg_idx_t;
   typedef logic [DEF_LAT_W-1:0] lat_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rs1;
      reg_idx_t rs2;
      logic     use_rs1;
      logic     use_rs2;
      reg_idx_t rd;
      logic     wr;
      lat_t     lat;
      logic     unpiped;
   } issue_slot_t;

endpackage

// File: rtl/scoreboard_regfile.sv
// Per-register pending-latency counters.
// Counters saturate at zero, can be loaded from the set ports, and are read combinationally.
module scoreboard_regfile
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int LAT_W    = DEF_LAT_W,
   parameter int N_RD     = 3 * DEF_ISSUE_WIDTH,
   parameter int N_SET    = DEF_ISSUE_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             hold,
   input  reg_idx_t         rd_idx  [N_RD],
   output logic [LAT_W-1:0] rd_cnt  [N_RD],
   input  logic [N_SET-1:0] set_en,
   input  reg_idx_t         set_idx [N_SET],
   input  logic [LAT_W-1:0] set_val [N_SET]
);

   logic [LAT_W-1:0] cnt_q [NUM_REGS];
   logic [LAT_W-1:0] cnt_d [NUM_REGS];

   always_comb begin
      cnt_d = cnt_q;
      if (!hold) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
         end
         // A new producer overrides the decrement of its destination.
         for (int i = 0; i < N_SET; i++) begin
            if (set_en[i] && set_idx[i] != '0) cnt_d[set_idx[i]] = set_val[i];
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '{default: '0};
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      for (int k = 0; k < N_RD; k++) rd_cnt[k] = cnt_q[rd_idx[k]];
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-slot issue-hazard unit: RAW/WAW against the latency scoreboard, intra-group
// dependences and the unpipelined-unit structural check, combined into prefix-closed stalls.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
   parameter int NUM_REGS    = DEF_NUM_REGS,
   parameter int LAT_W       = DEF_LAT_W,
   parameter int DIV_LAT     = DEF_DIV_LAT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     freeze,
   input  logic [ISSUE_WIDTH-1:0]   issue_valid,
   input  logic [ISSUE_WIDTH*5-1:0] issue_rs1,
   input  logic [ISSUE_WIDTH*5-1:0] issue_rs2,
   input  logic [ISSUE_WIDTH-1:0]   issue_use_rs1,
   input  logic [ISSUE_WIDTH-1:0]   issue_use_rs2,
   input  logic [ISSUE_WIDTH*5-1:0] issue_rd,
   input  logic [ISSUE_WIDTH-1:0]   issue_wr,
   input  logic [ISSUE_WIDTH*LAT_W-1:0] issue_lat,
   input  logic [ISSUE_WIDTH-1:0]   issue_unpiped,
   output logic [ISSUE_WIDTH-1:0]   stall,
   output logic [ISSUE_WIDTH-1:0]   issue_accept,
   output logic                     div_busy
);

   localparam int N_RD = 3 * ISSUE_WIDTH;

   issue_slot_t      slot    [ISSUE_WIDTH];
   logic [LAT_W-1:0] eff_lat [ISSUE_WIDTH];
   reg_idx_t         rd_idx  [N_RD];
   logic [LAT_W-1:0] rd_cnt  [N_RD];

   logic [ISSUE_WIDTH-1:0] raw_hz, waw_hz, grp_hz, str_hz;
   logic [ISSUE_WIDTH-1:0] raw_stall, stall_chain;
   logic                   blocked;

   logic [ISSUE_WIDTH-1:0] set_en;
   reg_idx_t               set_idx [ISSUE_WIDTH];
   logic [LAT_W-1:0]       set_val [ISSUE_WIDTH];

   logic [LAT_W-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         slot[i].valid   = issue_valid[i];
         slot[i].rs1     = issue_rs1[i*5 +: 5];
         slot[i].rs2     = issue_rs2[i*5 +: 5];
         slot[i].use_rs1 = issue_use_rs1[i];
         slot[i].use_rs2 = issue_use_rs2[i];
         slot[i].rd      = issue_rd[i*5 +: 5];
         slot[i].wr      = issue_wr[i];
         slot[i].lat     = lat_t'(issue_lat[i*LAT_W +: LAT_W]);
         slot[i].unpiped = issue_unpiped[i];
         eff_lat[i]      = slot[i].unpiped ? LAT_W'(DIV_LAT) : LAT_W'(slot[i].lat);
         rd_idx[2*i]             = slot[i].rs1;
         rd_idx[2*i+1]           = slot[i].rs2;
         rd_idx[2*ISSUE_WIDTH+i] = slot[i].rd;
      end
   end

   always_comb begin
      raw_hz      = '0;
      waw_hz      = '0;
      grp_hz      = '0;
      str_hz      = '0;
      raw_stall   = '0;
      stall_chain = '0;
      blocked     = 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         raw_hz[i] = (slot[i].use_rs1 && slot[i].rs1 != '0 && rd_cnt[2*i]   != '0) ||
                     (slot[i].use_rs2 && slot[i].rs2 != '0 && rd_cnt[2*i+1] != '0);
         // Keeps a short op from retiring its write ahead of an older long one.
         waw_hz[i] = slot[i].wr && slot[i].rd != '0 &&
                     (rd_cnt[2*ISSUE_WIDTH+i] > eff_lat[i]);
         str_hz[i] = slot[i].unpiped && (div_cnt_q != '0);
         for (int j = 0; j < i; j++) begin
            if (slot[j].valid && slot[j].wr && slot[j].rd != '0 &&
                ((slot[i].use_rs1 && slot[i].rs1 == slot[j].rd) ||
                 (slot[i].use_rs2 && slot[i].rs2 == slot[j].rd) ||
                 (slot[i].wr      && slot[i].rd  == slot[j].rd)))
               grp_hz[i] = 1'b1;
            if (slot[j].valid && slot[j].unpiped && slot[i].unpiped)
               str_hz[i] = 1'b1;
         end
         raw_stall[i]   = slot[i].valid && (raw_hz[i] || waw_hz[i] || grp_hz[i] || str_hz[i]);
         blocked        = blocked | raw_stall[i];
         stall_chain[i] = blocked;
      end
   end

   assign stall        = freeze ? '1 : stall_chain;
   assign issue_accept = issue_valid & ~stall;

   always_comb begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         set_en[i]  = issue_accept[i] && slot[i].wr && slot[i].rd != '0 && eff_lat[i] != '0;
         set_idx[i] = slot[i].rd;
         set_val[i] = eff_lat[i];
      end
   end

   scoreboard_regfile #(
      .NUM_REGS (NUM_REGS),
      .LAT_W    (LAT_W),
      .N_RD     (N_RD),
      .N_SET    (ISSUE_WIDTH)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .hold    (freeze),
      .rd_idx  (rd_idx),
      .rd_cnt  (rd_cnt),
      .set_en  (set_en),
      .set_idx (set_idx),
      .set_val (set_val)
   );

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!freeze) begin
         if (div_cnt_q != '0) div_cnt_d = div_cnt_q - LAT_W'(1);
         for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (issue_accept[i] && slot[i].unpiped) div_cnt_d = LAT_W'(DIV_LAT);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) div_cnt_q <= '0;
      else        div_cnt_q <= div_cnt_d;
   end

   assign div_busy = (div_cnt_q != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a ready-time reference model checked every cycle.
module tb_hazard_scoreboard;

   localparam int IW = 2;
   localparam int LW = 3;
   localparam int DL = 6;

   logic          clock;
   logic          reset;
   logic          freeze;
   logic [IW-1:0]    issue_valid;
   logic [IW*5-1:0]  issue_rs1, issue_rs2, issue_rd;
   logic [IW-1:0]    issue_use_rs1, issue_use_rs2, issue_wr, issue_unpiped;
   logic [IW*LW-1:0] issue_lat;
   logic [IW-1:0]    stall, issue_accept;
   logic             div_busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Model: a producer makes its register ready at a time stamp; time only advances on
   // clock edges that are neither frozen nor in reset.
   int tnow = 0;
   int ready [32];
   int div_ready = 0;
   logic [IW-1:0] m_es, m_ea;
   logic          m_eb;

   hazard_scoreboard dut (
      .clock         (clock),
      .reset         (reset),
      .freeze        (freeze),
      .issue_valid   (issue_valid),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_use_rs1 (issue_use_rs1),
      .issue_use_rs2 (issue_use_rs2),
      .issue_rd      (issue_rd),
      .issue_wr      (issue_wr),
      .issue_lat     (issue_lat),
      .issue_unpiped (issue_unpiped),
      .stall         (stall),
      .issue_accept  (issue_accept),
      .div_busy      (div_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit f_v(int i);   return issue_valid[i];   endfunction
   function automatic bit f_u1(int i);  return issue_use_rs1[i]; endfunction
   function automatic bit f_u2(int i);  return issue_use_rs2[i]; endfunction
   function automatic bit f_wr(int i);  return issue_wr[i];      endfunction
   function automatic bit f_unp(int i); return issue_unpiped[i]; endfunction
   function automatic int f_rs1(int i); return int'(issue_rs1[i*5 +: 5]); endfunction
   function automatic int f_rs2(int i); return int'(issue_rs2[i*5 +: 5]); endfunction
   function automatic int f_rd(int i);  return int'(issue_rd[i*5 +: 5]);  endfunction
   function automatic int f_lat(int i); return f_unp(i) ? DL : int'(issue_lat[i*LW +: LW]); endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) ready[r] = 0;
      div_ready = 0;
      tnow = 0;
   endtask

   task automatic model_eval(output logic [IW-1:0] es, output logic [IW-1:0] ea, output logic eb);
      bit blk;
      blk = 0;
      es  = '0;
      ea  = '0;
      for (int i = 0; i < IW; i++) begin
         bit hz;
         hz = 0;
         if (f_u1(i) && f_rs1(i) != 0 && ready[f_rs1(i)] > tnow) hz = 1;
         if (f_u2(i) && f_rs2(i) != 0 && ready[f_rs2(i)] > tnow) hz = 1;
         if (f_wr(i) && f_rd(i) != 0 && (ready[f_rd(i)] - tnow) > f_lat(i)) hz = 1;
         if (f_unp(i) && div_ready > tnow) hz = 1;
         for (int j = 0; j < i; j++) begin
            if (f_v(j) && f_wr(j) && f_rd(j) != 0 &&
                ((f_u1(i) && f_rs1(i) == f_rd(j)) || (f_u2(i) && f_rs2(i) == f_rd(j)) ||
                 (f_wr(i) && f_rd(i) == f_rd(j)))) hz = 1;
            if (f_v(j) && f_unp(j) && f_unp(i)) hz = 1;
         end
         if (f_v(i) && hz) blk = 1;
         if (freeze) blk = 1;
         es[i] = blk;
         ea[i] = f_v(i) && !blk;
      end
      eb = (div_ready > tnow);
   endtask

   always begin
      @(negedge clock);
      if (!reset) model_clear();
      model_eval(m_es, m_ea, m_eb);
      chk("model_stall", stall, m_es);
      chk("model_accept", issue_accept, m_ea);
      chk("model_busy", div_busy, m_eb);
      @(posedge clock);
      if (!reset) model_clear();
      else if (!freeze) begin
         for (int i = 0; i < IW; i++) begin
            if (m_ea[i]) begin
               if (f_wr(i) && f_rd(i) != 0 && f_lat(i) > 0) ready[f_rd(i)] = tnow + 1 + f_lat(i);
               if (f_unp(i)) div_ready = tnow + 1 + DL;
            end
         end
         tnow++;
      end
   end

   task automatic clr();
      issue_valid = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      issue_use_rs1 = '0; issue_use_rs2 = '0; issue_wr = '0; issue_lat = '0;
      issue_unpiped = '0;
   endtask

   task automatic slot(input int i, input int rd, input int rs1, input bit u1, input int rs2,
                       input bit u2, input bit wr, input int lat, input bit unp);
      issue_valid[i]       = 1'b1;
      issue_rd[i*5 +: 5]   = 5'(rd);
      issue_rs1[i*5 +: 5]  = 5'(rs1);
      issue_rs2[i*5 +: 5]  = 5'(rs2);
      issue_use_rs1[i]     = u1;
      issue_use_rs2[i]     = u2;
      issue_wr[i]          = wr;
      issue_lat[i*LW +: LW] = LW'(lat);
      issue_unpiped[i]     = unp;
   endtask

   task automatic alu(input int i, input int rd, input int rs1, input int rs2);
      slot(i, rd, rs1, 1'b1, rs2, 1'b1, 1'b1, 0, 1'b0);
   endtask
   task automatic ld(input int i, input int rd, input int rs1, input int lat);
      slot(i, rd, rs1, 1'b1, 0, 1'b0, 1'b1, lat, 1'b0);
   endtask
   task automatic dv(input int i, input int rd, input int rs1, input int rs2);
      slot(i, rd, rs1, 1'b1, rs2, 1'b1, 1'b1, 0, 1'b1);
   endtask

   task automatic settle(); @(negedge clock); endtask
   task automatic adv();    @(posedge clock); #1; endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset  = 1'b0;
      freeze = 1'b0;
      clr();
      repeat (2) @(posedge clock);
      #1;
      chk("reset_stall", stall, 0);
      chk("reset_busy", div_busy, 0);
      reset = 1'b1;

      // load-use, one bubble
      clr(); ld(0, 5, 1, 1);
      settle(); chk("lu_load_acc", issue_accept, 2'b01); adv();
      clr(); alu(0, 6, 5, 1); alu(1, 8, 2, 3);
      settle(); chk("lu_bubble_stall", stall, 2'b11); adv();
      settle(); chk("lu_go_stall", stall, 2'b00); chk("lu_go_acc", issue_accept, 2'b11); adv();

      // intra-group RAW, then the consumer moves to slot 0
      clr(); alu(0, 3, 1, 2); alu(1, 9, 3, 4);
      settle(); chk("grp_raw_stall", stall, 2'b10); chk("grp_raw_acc", issue_accept, 2'b01); adv();
      clr(); alu(0, 9, 3, 4);
      settle(); chk("grp_next_stall", stall, 2'b00); chk("grp_next_acc", issue_accept, 2'b01); adv();

      // intra-group WAW
      clr(); alu(0, 15, 1, 2); alu(1, 15, 4, 4);
      settle(); chk("grp_waw_stall", stall, 2'b10); adv();

      // divider occupancy, RAW on its result, WAW against it, structural on a second div
      clr(); dv(0, 7, 1, 2);
      settle(); chk("div_acc", issue_accept, 2'b01); adv();
      clr(); alu(0, 10, 7, 1);
      settle(); chk("div_raw_stall", stall, 2'b11); chk("div_busy_t1", div_busy, 1); adv();
      clr(); alu(0, 7, 0, 0);
      settle(); chk("div_waw_stall", stall, 2'b11); adv();
      clr(); dv(0, 11, 1, 2);
      for (int k = 0; k < 4; k++) begin
         settle(); chk("div_struct_stall", stall, 2'b11); adv();
      end
      settle(); chk("div_t7_stall", stall, 2'b00); chk("div_t7_acc", issue_accept, 2'b01);
      chk("div_t7_busy", div_busy, 0); adv();
      clr();
      repeat (7) begin settle(); adv(); end

      // two divs in one group
      clr(); dv(0, 12, 1, 2); dv(1, 13, 1, 2);
      settle(); chk("grp_struct_stall", stall, 2'b10); adv();
      clr();
      repeat (7) begin settle(); adv(); end

      // freeze holds a pending load
      clr(); ld(0, 5, 1, 1);
      settle(); adv();
      clr(); alu(0, 6, 5, 1); freeze = 1'b1;
      repeat (3) begin
         settle(); chk("frz_stall", stall, 2'b11); chk("frz_acc", issue_accept, 2'b00); adv();
      end
      freeze = 1'b0;
      settle(); chk("frz_rel_stall", stall, 2'b11); adv();
      settle(); chk("frz_go_stall", stall, 2'b00); chk("frz_go_acc", issue_accept, 2'b01); adv();

      // prefix rule and x0 sources
      clr(); ld(0, 5, 1, 1);
      settle(); adv();
      clr(); alu(0, 6, 5, 1); alu(1, 13, 1, 2);
      settle(); chk("prefix_stall", stall, 2'b11); adv();
      clr(); alu(1, 14, 0, 0);
      settle(); chk("x0_stall", stall, 2'b00); chk("x0_acc", issue_accept, 2'b10); adv();

      // latency 3, WAW of a shorter op, equal-latency WAW passes
      clr(); ld(0, 16, 1, 3);
      settle(); chk("lat3_acc", issue_accept, 2'b01); adv();
      clr(); ld(0, 16, 2, 1);
      settle(); chk("lat3_waw_stall", stall, 2'b11); adv();
      clr(); alu(0, 17, 16, 1);
      settle(); chk("lat3_raw_t2", stall, 2'b11); adv();
      settle(); chk("lat3_raw_t3", stall, 2'b11); adv();
      settle(); chk("lat3_go", issue_accept, 2'b01); adv();
      clr(); ld(0, 18, 1, 2);
      settle(); adv();
      clr(); ld(0, 18, 1, 2);
      settle(); chk("waw_eq_stall", stall, 2'b00); chk("waw_eq_acc", issue_accept, 2'b01); adv();
      clr();
      repeat (3) begin settle(); adv(); end

      // asynchronous reset with a pending load and a busy divider
      clr(); dv(0, 7, 1, 2);
      settle(); chk("rst_div_acc", issue_accept, 2'b01); adv();
      clr();
      settle(); adv();
      clr(); ld(0, 5, 1, 1);
      settle(); chk("rst_ld_acc", issue_accept, 2'b01); adv();
      clr(); alu(0, 6, 5, 7);
      settle(); chk("rst_pre_busy", div_busy, 1); chk("rst_pre_stall", stall, 2'b11);
      #1; reset = 1'b0; #1;
      chk("rst_async_busy", div_busy, 0); chk("rst_async_stall", stall, 2'b00);
      adv();
      settle(); adv();
      reset = 1'b1;
      clr(); alu(0, 6, 5, 7);
      settle(); chk("rst_after_stall", stall, 2'b00); chk("rst_after_acc", issue_accept, 2'b01); adv();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised per-slot issue-hazard unit for the N-wide in-order pipeline. Sits between the IF/ID register and ID/EX issue.
- Generalises the fixed load-use check into a per-register latency scoreboard (any producer latency), intra-group RAW/WAW detection and a structural check for one unpipelined unit (divider).
- Emits prefix-closed per-slot stalls and updates the scoreboard on accepted instructions.

Parameters:
- ISSUE_WIDTH, 2, number of issue slots (slot 0 oldest).
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- LAT_W, 3, width of the per-register latency counters and issue_lat.
- DIV_LAT, 6, busy cycles of the unpipelined unit; must be ≤ 2^LAT_W-1.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- freeze  in  1  downstream pipeline stall; hold all state, accept nothing
- issue_valid  in  ISSUE_WIDTH  slot holds an instruction
- issue_rs1 / issue_rs2  in  ISSUE_WIDTH×5  source register indices
- issue_use_rs1 / issue_use_rs2  in  ISSUE_WIDTH  source actually read
- issue_rd  in  ISSUE_WIDTH×5  destination index
- issue_wr  in  ISSUE_WIDTH  instruction writes rd
- issue_lat  in  ISSUE_WIDTH×LAT_W  producer latency: 0 = ALU (forwardable next cycle), 1 = load, etc.
- issue_unpiped  in  ISSUE_WIDTH  uses the unpipelined unit; its latency is DIV_LAT and issue_lat is ignored
- stall  out  ISSUE_WIDTH  slot must not issue this cycle
- issue_accept  out  ISSUE_WIDTH  = issue_valid & ~stall
- div_busy  out  1  unpipelined unit occupied

Behaviour:
- **State**
  - cnt[r], LAT_W bits, for r = 1..NUM_REGS-1.
  - div_cnt, LAT_W bits.
  - Reset: all counters 0. stall is combinational, so it is all 0 when all issue_valid are 0; div_busy = 0.
- **Read hazard (RAW)** for slot i: valid and a used source s ≠ 0 with cnt[s] ≠ 0.
- **Write hazard (WAW)** for slot i: issue_wr, rd ≠ 0, cnt[rd] > effective latency of slot i. This prevents a short op from overtaking a pending long op.
- **Intra-group hazard** for slot i: some earlier valid slot j < i writes rd_j ≠ 0 that is either:
  - a used source of slot i, or
  - equal to rd_i with issue_wr[i] set.
- **Structural hazard** for slot i: issue_unpiped[i] and either div_cnt ≠ 0 or an earlier valid slot is also unpiped.
- **Stall combination**
  - raw_stall[i] = valid[i] & (any of the four hazards).
  - stall[i] = raw_stall[i] | stall[i-1] (prefix-closed: an older stalled slot blocks all younger ones).
  - stall[i] = 1 for all i when freeze = 1.
- **Counter update, not frozen**
  - Each nonzero cnt and div_cnt decrements by 1 per cycle.
  - Then, for each accepted slot with wr, rd ≠ 0 and effective latency L > 0: cnt[rd] <= L. This overrides the decrement.
  - Accepted unpiped slot: div_cnt <= DIV_LAT and cnt[rd] <= DIV_LAT.
  - Accepted slots never write the same rd, because the intra-group rule prevents it.
- **Counter update, frozen**: all counters hold; no accepts.
- **Timing**
  - Producer accepted at cycle t with latency L: a dependent slot is stalled for cycles t+1..t+L and issues at t+L+1 at the earliest.
  - L = 1 gives the classic one-bubble load-use stall.
  - L = 0 never stalls a consumer in a later group.
- **Reset**: asserting reset mid-operation clears all counters immediately (asynchronous); the first cycle after deassertion sees an empty scoreboard.
- **Width and wrap**: no counter wraps (decrement saturates at 0). Latency values above 2^LAT_W-1 are illegal inputs.
- div_busy = (div_cnt ≠ 0).

Decomposition:
- hazard_pkg holds:
  - ISSUE_WIDTH and the LAT_W/DIV_LAT defaults
  - typedef reg_idx_t (5-bit)
  - typedef lat_t (LAT_W-bit)
  - struct issue_slot_t {valid, rs1, rs2, use_rs1, use_rs2, rd, wr, lat, unpiped}
- Sub-module scoreboard_regfile: counter array with decrement, set ports and a combinational read of cnt for 2×ISSUE_WIDTH sources plus ISSUE_WIDTH destinations.
- The top level holds the hazard logic, the prefix chain and div_cnt.

Test Plan:
- Load x5 (lat 1) accepted in slot 0 at t; at t+1 slot 0 is `add x6,x5,x1` -> stall=11 at t+1, stall=00 and accept=11 at t+2.
- ALU writes x3 in slot 0, slot 1 reads x3 in the same group -> stall=10, accept=01; next cycle slot 1 (moved to slot 0) issues with stall=00.
- Div to x7 accepted at t -> div_busy=1 for t+1..t+6. Second div at t+3 -> stalled until t+7. Read of x7 stalls through t+6. ALU write of x7 at t+2 -> WAW stall (cnt 5 > 0).
- freeze=1 for 3 cycles during a pending load (cnt=1) -> stall=11, counter holds at 1. After release, consumer stalls one more cycle, then issues.
- Slot 0 stalled on RAW, slot 1 independent -> stall=11 (prefix rule). Slot 0 valid=0 with slot 1 dependent on x0 -> stall=00.
- reset driven low while cnt[5]=1 and div_cnt=4 -> all counters 0 asynchronously, div_busy=0. After release, a dependent add issues with stall=00.
